load_progress_sequencer: RTL and testbench

- Frame-paced sequencer that produces the step count for the loading-screen progress bar renderer.
- Derives a once-per-frame tick from the video timing generator's vpos.
- Advances progress 0..MAX_STEPS at a fixed frame rate, then holds the full bar.
- Signals completion to the game control FSM with a done/ack handshake; the renderer consumes progress directly.

---
 rtl/load_progress_sequencer.sv | 143 ++++++++++++++
 tb/tb_load_progress_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_progress_sequencer.sv
// Frame-paced loading-bar sequencer: derives a per-frame tick from vpos, steps
// progress up to MAX_STEPS, holds the full bar, then handshakes done/ack.
module load_progress_sequencer #(
  parameter int unsigned MAX_STEPS       = 12,
  parameter int unsigned STEP_W          = 4,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned HOLD_FRAMES     = 30,
  parameter int unsigned FCNT_W          = 6,
  parameter int unsigned FRAME_LINE      = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        vpos,
  input  logic              start,
  input  logic              abort,
  input  logic              done_ack,
  output logic [STEP_W-1:0] progress,
  output logic              busy,
  output logic              done,
  output logic              frame_tick
);

  localparam int unsigned VPOS_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   progress_q, progress_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                frame_tick_q;
  logic [VPOS_W-1:0]   vpos_prev_q;
  logic                tick_c;

  // Rising into FRAME_LINE marks one frame; holding the line yields a single tick.
  assign tick_c = (vpos == VPOS_W'(FRAME_LINE)) && (vpos_prev_q != VPOS_W'(FRAME_LINE));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      progress_q   <= '0;
      fcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      vpos_prev_q  <= VPOS_W'(FRAME_LINE);
    end else begin
      state_q      <= state_d;
      progress_q   <= progress_d;
      fcnt_q       <= fcnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_tick_q <= tick_c;
      vpos_prev_q  <= vpos;
    end
  end

  // Next-state and registered-output logic; abort outranks tick in LOAD/HOLD.
  always_comb begin
    state_d    = state_q;
    progress_d = progress_q;
    fcnt_d     = fcnt_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          progress_d = '0;
          fcnt_d     = '0;
          busy_d     = 1'b1;
        end
      end

      LOAD: begin
        if (abort) begin
          state_d    = IDLE;
          progress_d = '0;
          fcnt_d     = '0;
          busy_d     = 1'b0;
        end else if (tick_c) begin
          if (fcnt_q == FCNT_W'(FRAMES_PER_STEP - 1)) begin
            fcnt_d     = '0;
            progress_d = progress_q + STEP_W'(1);
            if (progress_q == STEP_W'(MAX_STEPS - 1)) begin
              state_d = HOLD;
            end
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end

      HOLD: begin
        if (abort) begin
          state_d    = IDLE;
          progress_d = '0;
          fcnt_d     = '0;
          busy_d     = 1'b0;
        end else if (tick_c) begin
          if (fcnt_q == FCNT_W'(HOLD_FRAMES - 1)) begin
            state_d = DONE;
            fcnt_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end

      DONE: begin
        // start is deliberately not looked at here; it must be re-presented in IDLE.
        if (done_ack) begin
          state_d    = IDLE;
          progress_d = '0;
          done_d     = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        progress_d = '0;
        fcnt_d     = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  assign progress   = progress_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_load_progress_sequencer.sv
// Directed bench for load_progress_sequencer: default instance plus a small
// MAX_STEPS=3 / FRAMES_PER_STEP=1 / HOLD_FRAMES=1 instance sharing clk/reset/vpos.
module tb_load_progress_sequencer;

  logic       clk;
  logic       reset;
  logic [9:0] vpos;
  logic       start, abort, done_ack;
  logic [3:0] progress;
  logic       busy, done, frame_tick;

  logic       start_s, abort_s, done_ack_s;
  logic [3:0] progress_s;
  logic       busy_s, done_s, frame_tick_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Compressed frame: a few lines either side of FRAME_LINE, one cycle each.
  int frame_seq [6] = '{0, 240, 479, 480, 481, 524};

  load_progress_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .vpos       (vpos),
    .start      (start),
    .abort      (abort),
    .done_ack   (done_ack),
    .progress   (progress),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  load_progress_sequencer #(
    .MAX_STEPS       (3),
    .STEP_W          (4),
    .FRAMES_PER_STEP (1),
    .HOLD_FRAMES     (1),
    .FCNT_W          (6),
    .FRAME_LINE      (480)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .vpos       (vpos),
    .start      (start_s),
    .abort      (abort_s),
    .done_ack   (done_ack_s),
    .progress   (progress_s),
    .busy       (busy_s),
    .done       (done_s),
    .frame_tick (frame_tick_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(output int ticks);
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      vpos = 10'(frame_seq[i]);
      step();
      if (frame_tick) ticks++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; vpos = 10'd480;
    start = 0; abort = 0; done_ack = 0;
    start_s = 0; abort_s = 0; done_ack_s = 0;
    step(); step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (frame_tick !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_tick cyc%0d: frame_tick=%b expected 0", i, frame_tick);
      end
    end
    n_checks++;
    if (progress !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: progress=%0d busy=%b done=%b expected 0/0/0", progress, busy, done);
    end
  endtask

  task automatic test_tick_hold();
    int ticks;
    ticks = 0;
    vpos = 10'd0; step();
    vpos = 10'd480;
    for (int i = 0; i < 5; i++) begin
      step();
      if (frame_tick) ticks++;
    end
    vpos = 10'd524; step();
    n_checks++;
    if (ticks !== 1) begin
      n_fail++; $display("FAIL tick_held_line: ticks=%0d expected 1", ticks);
    end
    n_checks++;
    if (busy !== 1'b0 || progress !== 4'd0) begin
      n_fail++; $display("FAIL tick_idle_no_load: busy=%b progress=%0d expected 0/0", busy, progress);
    end
  endtask

  task automatic test_default_run();
    int ticks, exp_p;
    logic exp_d;
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || progress !== 4'd0) begin
      n_fail++; $display("FAIL start_latency: busy=%b progress=%0d expected 1/0", busy, progress);
    end
    for (int k = 1; k <= 78; k++) begin
      drive_frame(ticks);
      exp_p = (k / 4 > 12) ? 12 : k / 4;
      exp_d = (k >= 78);
      n_checks++;
      if (ticks !== 1) begin
        n_fail++; $display("FAIL frame_tick_count frame%0d: ticks=%0d expected 1", k, ticks);
      end
      n_checks++;
      if (progress !== 4'(exp_p) || done !== exp_d || busy !== !exp_d) begin
        n_fail++;
        $display("FAIL run_frame%0d: progress=%0d done=%b busy=%b expected %0d/%b/%b",
                 k, progress, done, busy, exp_p, exp_d, !exp_d);
      end
    end
  endtask

  task automatic test_done_hold();
    int ticks;
    for (int k = 0; k < 5; k++) begin
      abort = (k == 2);
      drive_frame(ticks);
      abort = 1'b0;
      n_checks++;
      if (done !== 1'b1 || progress !== 4'd12 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_hold frame%0d: done=%b progress=%0d busy=%b expected 1/12/0", k, done, progress, busy);
      end
    end
    done_ack = 1'b1; start = 1'b1; step();
    done_ack = 1'b0; start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || progress !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ack_exit: done=%b progress=%0d busy=%b expected 0/0/0", done, progress, busy);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL no_restart_from_done: busy=%b expected 0", busy);
    end
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || progress !== 4'd0) begin
      n_fail++; $display("FAIL restart: busy=%b progress=%0d expected 1/0", busy, progress);
    end
  endtask

  task automatic test_abort();
    int ticks;
    for (int k = 0; k < 31; k++) drive_frame(ticks);
    n_checks++;
    if (progress !== 4'd7 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_abort: progress=%0d busy=%b expected 7/1", progress, busy);
    end
    vpos = 10'd0;   step();
    vpos = 10'd479; step();
    vpos = 10'd480; abort = 1'b1; start = 1'b1; step();
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if (progress !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_on_tick: progress=%0d busy=%b done=%b expected 0/0/0", progress, busy, done);
    end
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++; $display("FAIL abort_tick_pulse: frame_tick=%b expected 1", frame_tick);
    end
    vpos = 10'd481; step();
    vpos = 10'd524; step();
    n_checks++;
    if (progress !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_abort_idle: progress=%0d busy=%b expected 0/0", progress, busy);
    end
  endtask

  task automatic test_small_params();
    int ticks;
    logic [3:0] exp_p [4];
    logic       exp_d [4];
    exp_p = '{4'd1, 4'd2, 4'd3, 4'd3};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b1};
    start_s = 1'b1; step(); start_s = 1'b0;
    n_checks++;
    if (busy_s !== 1'b1 || progress_s !== 4'd0) begin
      n_fail++; $display("FAIL small_start: busy=%b progress=%0d expected 1/0", busy_s, progress_s);
    end
    for (int k = 0; k < 4; k++) begin
      drive_frame(ticks);
      n_checks++;
      if (progress_s !== exp_p[k] || done_s !== exp_d[k] || busy_s !== !exp_d[k]) begin
        n_fail++;
        $display("FAIL small_tick%0d: progress=%0d done=%b busy=%b expected %0d/%b/%b",
                 k + 1, progress_s, done_s, busy_s, exp_p[k], exp_d[k], !exp_d[k]);
      end
    end
    done_ack_s = 1'b1; step(); done_ack_s = 1'b0;
    n_checks++;
    if (done_s !== 1'b0 || progress_s !== 4'd0) begin
      n_fail++; $display("FAIL small_ack: done=%b progress=%0d expected 0/0", done_s, progress_s);
    end
  endtask

  task automatic test_reset_in_hold();
    int ticks;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 50; k++) drive_frame(ticks);
    n_checks++;
    if (progress !== 4'd12 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL in_hold: progress=%0d busy=%b done=%b expected 12/1/0", progress, busy, done);
    end
    vpos = 10'd479; step();
    vpos = 10'd480; reset = 1'b0; step();
    n_checks++;
    if (progress !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_hold: progress=%0d busy=%b done=%b tick=%b expected 0/0/0/0",
               progress, busy, done, frame_tick);
    end
    step();
    reset = 1'b1; step();
    n_checks++;
    if (frame_tick !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_quiet: tick=%b busy=%b expected 0/0", frame_tick, busy);
    end
    step();
    n_checks++;
    if (frame_tick !== 1'b0 || progress !== 4'd0) begin
      n_fail++; $display("FAIL post_reset_idle: tick=%b progress=%0d expected 0/0", frame_tick, progress);
    end
  endtask

  initial begin
    test_reset();
    test_tick_hold();
    test_default_run();
    test_done_hold();
    test_abort();
    test_small_params();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
